// File: rtl/up_down_counter.sv
// up_down_counter: WIDTH-bit synchronous up/down counter with count enable
module up_down_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             upcount,
  input  logic             enable,
  output logic [WIDTH-1:0] out
);
  localparam logic [WIDTH-1:0] one = 1;
  logic [WIDTH-1:0] count_next;
  always_comb count_next = !enable ? out : upcount ? out + one : out - one;
  always_ff @(posedge clk)
    out <= !reset_n ? '0 : count_next;
endmodule

// File: tb/tb_up_down_counter.sv
// tb_up_down_counter: directed checks of reset, hold, both directions and wrap
module tb_up_down_counter;
  logic       clk = 0;
  logic       reset_n = 0;
  logic       upcount = 1;
  logic       enable = 0;
  logic [4:0] out;
  int         n_cmp = 0;
  int         n_bad = 0;

  up_down_counter #(.WIDTH(5)) dut (
    .clk(clk), .reset_n(reset_n), .upcount(upcount), .enable(enable), .out(out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic en, input logic up, input logic [4:0] exp,
                      input string tag);
    reset_n = r;
    enable  = en;
    upcount = up;
    @(posedge clk);
    #1;
    check(tag, out, exp);
  endtask

  initial begin
    #1;
    step(0, 0, 1, 5'd0, "reset_c1");
    step(0, 0, 1, 5'd0, "reset_c2");
    for (int i = 1; i <= 5; i++) step(1, 1, 1, 5'(i), "release_up");
    step(1, 0, 1, 5'd5, "hold_c1");
    step(1, 0, 0, 5'd5, "hold_c2");
    step(1, 1, 1, 5'd6, "reenable_6");
    step(1, 1, 1, 5'd7, "reenable_7");
    // inputs toggled between edges must not reach out
    reset_n = 0; enable = 1; upcount = 0;
    #3;
    check("no_comb_path", out, 5'd7);
    step(0, 0, 1, 5'd0, "reset_before_wrap");
    for (int i = 1; i <= 31; i++) step(1, 1, 1, 5'(i), "up_run");
    step(1, 1, 1, 5'd0, "up_wrap_31_0");
    step(1, 1, 1, 5'd1, "after_wrap_1");
    step(1, 1, 1, 5'd2, "after_wrap_2");
    for (int i = 3; i <= 25; i++) step(1, 1, 1, 5'(i), "up_to_25");
    for (int i = 24; i >= 0; i--) step(1, 1, 0, 5'(i), "down_run");
    step(1, 1, 0, 5'd31, "down_wrap_0_31");
    step(1, 1, 0, 5'd30, "down_after_wrap");
    step(1, 1, 1, 5'd31, "dir_up_again");
    step(1, 1, 0, 5'd30, "dir_flip_down");
    step(0, 0, 1, 5'd0, "reset_before_mid");
    for (int i = 1; i <= 6; i++) step(1, 1, 1, 5'(i), "up_to_6");
    step(1, 1, 0, 5'd5, "down_to_5");
    step(0, 1, 0, 5'd0, "mid_reset");
    step(1, 1, 0, 5'd31, "resume_down_31");
    step(1, 1, 1, 5'd0, "resume_up_wrap");
    step(1, 1, 1, 5'd1, "count_1");
    step(1, 1, 1, 5'd2, "count_2");
    for (int i = 0; i < 3; i++) step(0, 1, 1, 5'd0, "reset_prio_up");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 5'd0, "reset_prio_down");
    step(1, 1, 0, 5'd31, "release_down_31");
    step(1, 0, 1, 5'd31, "hold_31");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
